// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: result channels from ALU/MUL/DIV, flush, and the
// completion bus toward the ROB.
//   <x>_valid/_ready   push handshake per source (x = alu, mul, div)
//   <x>_value/_index   32-bit result value and ROB index
//   <x>_phys           7-bit destination physical register
//   flush              drop every buffered result
//   cdb_*              registered completion bus (valid, value, index,
//                      phys_addr, src)
// Modports: master = execution units / ROB side, slave = arbiter.
interface cdb_arbiter_if;
  logic        alu_valid;
  logic        alu_ready;
  logic [31:0] alu_value;
  logic [31:0] alu_index;
  logic [6:0]  alu_phys;
  logic        mul_valid;
  logic        mul_ready;
  logic [31:0] mul_value;
  logic [31:0] mul_index;
  logic [6:0]  mul_phys;
  logic        div_valid;
  logic        div_ready;
  logic [31:0] div_value;
  logic [31:0] div_index;
  logic [6:0]  div_phys;
  logic        flush;
  logic        cdb_valid;
  logic [31:0] cdb_value;
  logic [31:0] cdb_index;
  logic [6:0]  cdb_phys_addr;
  logic [1:0]  cdb_src;

  modport master (
    output alu_valid, alu_value, alu_index, alu_phys,
    output mul_valid, mul_value, mul_index, mul_phys,
    output div_valid, div_value, div_index, div_phys,
    output flush,
    input  alu_ready, mul_ready, div_ready,
    input  cdb_valid, cdb_value, cdb_index,
    input  cdb_phys_addr, cdb_src
  );

  modport slave (
    input  alu_valid, alu_value, alu_index, alu_phys,
    input  mul_valid, mul_value, mul_index, mul_phys,
    input  div_valid, div_value, div_index, div_phys,
    input  flush,
    output alu_ready, mul_ready, div_ready,
    output cdb_valid, cdb_value, cdb_index,
    output cdb_phys_addr, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: three result FIFOs (ALU=0, MUL=1, DIV=2) sharing one
// registered completion bus, round-robin, one grant per cycle.
// Ports: clk, rst (async, active high), bus (cdb_arbiter_if.slave).
// Parameter DEPTH: entries per FIFO, power of two, >= 2.
// Macro CDB_ARB_BYPASS_EN: an empty FIFO with valid input may win
// directly (1-cycle latency); undefined gives 2-cycle minimum latency.
module cdb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  cdb_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
`ifdef CDB_ARB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // entry layout: {value[31:0], index[31:0], phys[6:0]}
  typedef logic [70:0] ent_t;

  logic [2:0]    in_v;
  ent_t          in_d   [3];
  logic [2:0]    rdy;

  ent_t          mem_q  [3][DEPTH];
  logic [AW-1:0] wptr_q [3];
  logic [AW-1:0] wptr_d [3];
  logic [AW-1:0] rptr_q [3];
  logic [AW-1:0] rptr_d [3];
  logic [CW-1:0] cnt_q  [3];
  logic [CW-1:0] cnt_d  [3];
  logic [1:0]    last_q;
  logic [1:0]    last_d;
  logic          cdb_valid_q;
  logic          cdb_valid_d;
  ent_t          cdb_data_q;
  ent_t          cdb_data_d;
  logic [1:0]    cdb_src_q;
  logic [1:0]    cdb_src_d;

  logic [2:0]    cand;
  logic [2:0]    pop;
  logic [2:0]    wr_en;
  logic          grant;
  logic [1:0]    win;
  ent_t          head   [3];

  function automatic logic [1:0] rr_next(
    input logic [1:0] base,
    input int         k
  );
    return 2'((int'(base) + k) % 3);
  endfunction

  assign in_v = {bus.div_valid, bus.mul_valid, bus.alu_valid};
  assign in_d[0] = {bus.alu_value, bus.alu_index, bus.alu_phys};
  assign in_d[1] = {bus.mul_value, bus.mul_index, bus.mul_phys};
  assign in_d[2] = {bus.div_value, bus.div_index, bus.div_phys};

  assign bus.alu_ready     = rdy[0];
  assign bus.mul_ready     = rdy[1];
  assign bus.div_ready     = rdy[2];
  assign bus.cdb_valid     = cdb_valid_q;
  assign bus.cdb_value     = cdb_data_q[70:39];
  assign bus.cdb_index     = cdb_data_q[38:7];
  assign bus.cdb_phys_addr = cdb_data_q[6:0];
  assign bus.cdb_src       = cdb_src_q;

  always_comb begin
    for (int s = 0; s < 3; s++) begin
      // registered count only: a pop never raises ready this cycle
      rdy[s]  = !rst && (cnt_q[s] != FULL);
      head[s] = mem_q[s][rptr_q[s]];
      cand[s] = (cnt_q[s] != '0) || (BYPASS && in_v[s]);
    end

    grant = 1'b0;
    win   = 2'd0;
    for (int k = 1; k <= 3; k++) begin
      if (!grant && cand[rr_next(last_q, k)]) begin
        grant = 1'b1;
        win   = rr_next(last_q, k);
      end
    end

    pop         = '0;
    wr_en       = '0;
    last_d      = last_q;
    cdb_valid_d = 1'b0;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    for (int s = 0; s < 3; s++) begin
      wptr_d[s] = wptr_q[s];
      rptr_d[s] = rptr_q[s];
      cnt_d[s]  = cnt_q[s];
    end

    if (bus.flush) begin
      for (int s = 0; s < 3; s++) begin
        wptr_d[s] = '0;
        rptr_d[s] = '0;
        cnt_d[s]  = '0;
      end
    end else begin
      if (grant) begin
        cdb_valid_d = 1'b1;
        cdb_src_d   = win;
        last_d      = win;
        // an empty winner can only be a bypass candidate
        cdb_data_d  = (cnt_q[win] != '0) ? head[win] : in_d[win];
      end
      for (int s = 0; s < 3; s++) begin
        pop[s]   = grant && (win == 2'(s)) && (cnt_q[s] != '0);
        // a bypassed winner goes straight to the bus, not the FIFO
        wr_en[s] = in_v[s] && rdy[s] &&
                   !(grant && (win == 2'(s)) && (cnt_q[s] == '0));
        if (pop[s])   rptr_d[s] = rptr_q[s] + AW'(1);
        if (wr_en[s]) wptr_d[s] = wptr_q[s] + AW'(1);
        cnt_d[s] = cnt_q[s] + CW'(wr_en[s]) - CW'(pop[s]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < 3; s++) begin
        wptr_q[s] <= '0;
        rptr_q[s] <= '0;
        cnt_q[s]  <= '0;
      end
      last_q      <= 2'd2;
      cdb_valid_q <= 1'b0;
      cdb_data_q  <= '0;
      cdb_src_q   <= 2'd0;
    end else begin
      for (int s = 0; s < 3; s++) begin
        wptr_q[s] <= wptr_d[s];
        rptr_q[s] <= rptr_d[s];
        cnt_q[s]  <= cnt_d[s];
      end
      last_q      <= last_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  // storage needs no reset: counts gate every read
  always_ff @(posedge clk) begin
    for (int s = 0; s < 3; s++) begin
      if (wr_en[s]) mem_q[s][wptr_q[s]] <= in_d[s];
    end
  end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Completion-bus arbiter that shares the ROB's single write-back path among the ALU, multiplier and divider. Each execution unit pushes results (value, ROB index, physical address) through a valid/ready handshake into a private FIFO. The arbiter selects one result per cycle round-robin and drives a registered completion bus into the ROB. A flush input discards all buffered results on branch mispredict.

## Interface
- DEPTH, 2, entries per source FIFO; power of two, ≥2
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- alu_valid / mul_valid / div_valid  input  1 each  result offered by unit
- alu_ready / mul_ready / div_ready  output  1 each  FIFO can accept this cycle
- alu_value / mul_value / div_value  input  32 each  result value
- alu_index / mul_index / div_index  input  32 each  ROB index of result
- alu_phys / mul_phys / div_phys  input  7 each  destination physical register
- flush  input  1  discard all buffered and in-flight results
- cdb_valid  output  1  completion bus valid, one cycle per result
- cdb_value  output  32  granted value
- cdb_index  output  32  granted ROB index
- cdb_phys_addr  output  7  granted physical address
- cdb_src  output  2  granted source: 0 ALU, 1 MUL, 2 DIV; 3 unused

## Operation
- Per source: FIFO of DEPTH entries × 71 bits, read/write pointers, count of $clog2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
- x_ready = !rst && (count_x != DEPTH); depends on registered count only, so a pop does not raise ready in the same cycle.
- Push when x_valid && x_ready; the source holds its data stable while valid && !ready.
- Arbitration: candidates are non-empty FIFOs (plus bypass candidates, see Configuration). Round-robin pointer last_grant (2 bits) sets priority order starting at last_grant+1 mod 3. Grant pops the winner's FIFO head, loads the cdb_* registers, sets cdb_valid=1 and last_grant=winner.
- No candidate: cdb_valid=0; cdb_value/index/phys_addr/src hold their previous values.
- The ROB always accepts; the completion bus has no backpressure.
- flush (synchronous, highest priority): all counts and pointers go to 0, pushes in that cycle are dropped, no grant, cdb_valid=0 next cycle. last_grant is unchanged.
- Simultaneous push and pop on one FIFO: count is unchanged and both pointers advance.
- Reset: FIFOs empty, last_grant=2 (ALU wins first), cdb_valid=0, cdb_value=0, cdb_index=0, cdb_phys_addr=0, cdb_src=0; ready outputs are 0 while rst is high.

## Timing
- Single-source throughput: 1 result per cycle per granted source.
- Aggregate throughput: 1 result per cycle.
- Latency, accepted push to cdb_valid: 2 cycles through the FIFO; 1 cycle with bypass.
- Worst-case wait of a non-empty source: 2 grant cycles (round-robin fairness).
- Results from one source leave in arrival order; order across sources is not guaranteed.
- A push in the cycle rst deasserts is not accepted, because ready was 0 in that cycle.

## Configuration
- CDB_ARB_BYPASS_EN defined: a source whose FIFO is empty and presents valid is a candidate that cycle. If it wins, the data goes directly to the cdb_* registers (1-cycle latency) and is not written into the FIFO. If it loses, it is pushed normally.
- CDB_ARB_BYPASS_EN undefined: only FIFO contents are candidates; minimum latency is 2 cycles.
- Arbitration order and fairness are identical in both builds.

## Test plan
- Single ALU push, value=0x1234, index=5, phys=9 -> cdb_valid for one cycle with those values and src=0, 2 cycles after the push (1 with bypass).
- ALU, MUL and DIV all push in the same cycle after reset -> grants in order ALU, MUL, DIV on 3 consecutive cycles; cdb_valid stays high for 3 cycles.
- Continuous ALU pushes with no MUL/DIV traffic -> one result per cycle, in order, and alu_ready stays 1.
- DIV pushes DEPTH+1 back-to-back while ALU and MUL saturate the bus -> div_ready drops to 0 after DEPTH pushes; the held item is later accepted and no result is lost or duplicated.
- flush while FIFOs hold 3 entries and a MUL push is active -> the push is dropped, cdb_valid=0 on the next cycle, and the next ALU push emerges alone.
- rst asserted mid-stream (asynchronous, mid-cycle) -> cdb_valid=0 and all ready=0 immediately; after release, the first grant goes to ALU.
